// File: rtl/wb_chk_pkg.sv
// Shared types and constants for the writeback scoreboard.
package wb_chk_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPass = 2'd2,
    StFail = 2'd3
  } state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_MISMATCH = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAIL_EXTRA    = 2'd3;

  // One table entry packs {register, value}.
  function automatic int unsigned entry_w(input int unsigned reg_aw, input int unsigned data_w);
    return reg_aw + data_w;
  endfunction

endpackage

// File: rtl/exp_table.sv
// Expected-result table: one synchronous write port, one combinational read port.
module exp_table #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [REG_AW-1:0] wreg,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [REG_AW-1:0] rreg,
  output logic [DATA_W-1:0] rdata
);
  import wb_chk_pkg::*;

  localparam int unsigned EntryW = entry_w(REG_AW, DATA_W);

  logic [EntryW-1:0] mem [DEPTH];

  // Table write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {wreg, wdata};
  end

  assign {rreg, rdata} = mem[raddr];

endmodule

// File: rtl/wb_scoreboard.sv
// In-order register-writeback checker: compares CPU writes against a preloaded table.
module wb_scoreboard
  import wb_chk_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = $clog2(DEPTH) + 1,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] end_pc,
  input  logic [DATA_W-1:0] pc,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exp_we,
  input  logic [IDX_W-2:0]  exp_waddr,
  input  logic [REG_AW-1:0] exp_wreg,
  input  logic [DATA_W-1:0] exp_wdata,
  input  logic [IDX_W-1:0]  exp_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W-1:0]  err_index,
  output logic [DATA_W-1:0] err_got,
  output logic [DATA_W-1:0] err_exp,
  output logic [IDX_W-1:0]  checks_done,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned AW = IDX_W - 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [1:0]        code_q, code_d;
  logic [IDX_W-1:0]  eidx_q, eidx_d;
  logic [DATA_W-1:0] egot_q, egot_d;
  logic [DATA_W-1:0] eexp_q, eexp_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;

  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic              counted;
  logic              run_fail;
  logic [IDX_W-1:0]  count_clamped;

  exp_table #(
    .DEPTH (DEPTH),
    .REG_AW(REG_AW),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_table (
    .clk  (clk),
    .we   (exp_we && (state_q == StIdle)),
    .waddr(exp_waddr),
    .wreg (exp_wreg),
    .wdata(exp_wdata),
    .raddr(idx_q[AW-1:0]),
    .rreg (rd_reg),
    .rdata(rd_data)
  );

  assign counted       = wb_en && (wb_addr != '0);
  assign count_clamped = (exp_count > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : exp_count;

  // Next-state: start handling, in-order compare, end-PC and timeout resolution.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    code_d   = code_q;
    eidx_d   = eidx_q;
    egot_d   = egot_q;
    eexp_d   = eexp_q;
    cyc_d    = cyc_q;
    run_fail = 1'b0;
    unique case (state_q)
      StIdle, StPass, StFail: begin
        if (start) begin
          state_d = StRun;
          count_d = count_clamped;
          idx_d   = '0;
          code_d  = FAIL_NONE;
          eidx_d  = '0;
          egot_d  = '0;
          eexp_d  = '0;
          cyc_d   = '0;
        end
      end
      StRun: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        if (counted) begin
          if (idx_q < count_q) begin
            if ((rd_reg == wb_addr) && (rd_data == wb_data)) begin
              idx_d = idx_q + IDX_W'(1);
            end else begin
              run_fail = 1'b1;
              code_d   = FAIL_MISMATCH;
              eidx_d   = idx_q;
              egot_d   = wb_data;
              eexp_d   = rd_data;
            end
          end else begin
            run_fail = 1'b1;
            code_d   = FAIL_EXTRA;
            eidx_d   = count_q;
            egot_d   = wb_data;
            eexp_d   = '0;
          end
        end
        if (run_fail) begin
          state_d = StFail;
        end else if ((pc == end_pc) && (idx_d == count_q)) begin
          state_d = StPass;
        end else if (32'(cyc_d) >= TIMEOUT) begin
          state_d = StFail;
          code_d  = FAIL_TIMEOUT;
          eidx_d  = idx_d;
          egot_d  = '0;
          eexp_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and status registers; reset clears everything but the table.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      count_q <= '0;
      code_q  <= FAIL_NONE;
      eidx_q  <= '0;
      egot_q  <= '0;
      eexp_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
      egot_q  <= egot_d;
      eexp_q  <= eexp_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StPass) || (state_q == StFail);
  assign pass        = (state_q == StPass);
  assign fail_code   = code_q;
  assign err_index   = eidx_q;
  assign err_got     = egot_q;
  assign err_exp     = eexp_q;
  assign checks_done = idx_q;
  assign cycle_count = cyc_q;

endmodule
